// File: rtl/sample_sequencer.sv
// sample_sequencer: round-robin converter poller on the EBI register bus.
// Strobes each channel in the unit table, waits SETTLE_CYCLES, captures the
// sample and pushes a tagged word {idx, sample} into a FIFO drained via a
// pop register. Optional change-only filtering and an overflow counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   addr, ebi_data_in EBI address / write data
//   cs, re, wr        EBI chip select, read strobe, write strobe
//   ebi_data_out      registered EBI read data
//   output_sample     converter strobe for the channel being polled
//   channel_select    table entry of the channel being polled (255 if none)
//   sample_data       converter data, low SAMPLE_W bits used
//   sampling          high while the sequencer is not idle
//   data_avail        FIFO not empty
module sample_sequencer #(
    parameter int unsigned POSITION      = 242,
    parameter int unsigned MAX_UNITS     = 8,
    parameter int unsigned SAMPLE_W      = 13,
    parameter int unsigned FIFO_DEPTH    = 1024,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] ebi_data_in,
    output logic [15:0] ebi_data_out,
    input  logic        cs,
    input  logic        re,
    input  logic        wr,
    output logic        output_sample,
    output logic [7:0]  channel_select,
    input  logic [31:0] sample_data,
    output logic        sampling,
    output logic        data_avail
);

    localparam int unsigned IDX_W = $clog2(MAX_UNITS);
    localparam int unsigned NU_W  = IDX_W + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [7:0] REG_NEXT_SAMPLE = 8'h01;
    localparam logic [7:0] REG_NUM_SAMPLES = 8'h02;
    localparam logic [7:0] REG_NEW_UNIT    = 8'h04;
    localparam logic [7:0] REG_COMMAND     = 8'h05;
    localparam logic [7:0] REG_NUM_UNITS   = 8'h06;
    localparam logic [7:0] REG_CONFIG      = 8'h07;
    localparam logic [7:0] REG_OVERFLOW    = 8'h08;
    localparam logic [7:0] REG_DEBUG       = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_CAPTURE,
        S_COMMIT
    } state_t;

    state_t state, state_next;

    logic                rd_active, wr_active, rd_active_q, wr_active_q;
    logic                rd_stb, wr_stb, hit;
    logic                cmd_start, cmd_stop, cmd_reset, unit_add, cfg_write, pop_req;
    logic                stop_q, stop_seen, change_only;
    logic [7:0]          settle_cnt;
    logic [SAMPLE_W-1:0] cap_reg;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [NU_W-1:0]     num_units, num_units_next;
    logic [7:0]          unit_table [MAX_UNITS];
    logic [SAMPLE_W-1:0] last_val [MAX_UNITS];
    logic [15:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_next;
    logic [15:0]         overflow;
    logic                commit, want_push, push, pop, fifo_empty, fifo_full;
    logic [15:0]         push_word, rd_value, num_samples_sat;
    logic [7:0]          sel_entry;
    logic                unused_sample_bits;

    assign unused_sample_bits = ^sample_data[31:SAMPLE_W];

    // Bus decode; strobes fire only on the first cycle of an access
    assign hit       = cs && (addr[15:8] == 8'(POSITION));
    assign rd_active = hit && re;
    assign wr_active = hit && wr;
    assign rd_stb    = rd_active && !rd_active_q;
    assign wr_stb    = wr_active && !wr_active_q;

    assign cmd_start = wr_stb && (addr[7:0] == REG_COMMAND) && (ebi_data_in == 16'd1);
    assign cmd_stop  = wr_stb && (addr[7:0] == REG_COMMAND) && (ebi_data_in == 16'd2);
    assign cmd_reset = wr_stb && (addr[7:0] == REG_COMMAND) && (ebi_data_in == 16'd5);
    assign cfg_write = wr_stb && (addr[7:0] == REG_CONFIG);
    assign unit_add  = wr_stb && (addr[7:0] == REG_NEW_UNIT) && (state == S_IDLE)
                       && (num_units < NU_W'(MAX_UNITS)) && !cmd_reset;
    assign pop_req   = rd_stb && (addr[7:0] == REG_NEXT_SAMPLE);

    assign stop_seen = stop_q || cmd_stop;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (cmd_start && (num_units != '0)) state_next = S_FETCH;
            S_FETCH:   state_next = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
            S_SETTLE:  if (settle_cnt == 8'(SETTLE_CYCLES - 1)) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_COMMIT;
            S_COMMIT:  state_next = stop_seen ? S_IDLE : S_FETCH;
            default:   state_next = S_IDLE;
        endcase
        if (cmd_reset) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Push/pop decision; a pop on a full FIFO makes room for this cycle's push
    always_comb begin
        commit     = (state == S_COMMIT) && !cmd_reset;
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        want_push  = commit && (!change_only || (cap_reg != last_val[idx]));
        pop        = pop_req && !fifo_empty && !cmd_reset;
        push       = want_push && (!fifo_full || pop);
        push_word  = 16'({idx, cap_reg});

        count_next = count;
        if (cmd_reset)         count_next = '0;
        else if (push && !pop) count_next = count + CNT_W'(1);
        else if (pop && !push) count_next = count - CNT_W'(1);

        idx_next = idx;
        if (cmd_reset) idx_next = '0;
        else if (commit)
            idx_next = (NU_W'(idx) == num_units - NU_W'(1)) ? '0 : idx + IDX_W'(1);

        num_units_next = num_units;
        if (cmd_reset)     num_units_next = '0;
        else if (unit_add) num_units_next = num_units + NU_W'(1);

        // Entry being appended is not in the table yet, so forward it
        sel_entry = unit_table[idx_next];
        if (unit_add && (NU_W'(idx_next) == num_units)) sel_entry = ebi_data_in[7:0];
    end

    // Register read mux
    always_comb begin
        num_samples_sat = (32'(count) > 32'h0000_FFFF) ? 16'hFFFF : 16'(count);
        rd_value = '0;
        case (addr[7:0])
            REG_NEXT_SAMPLE: rd_value = fifo_empty ? 16'h0000 : mem[rd_ptr];
            REG_NUM_SAMPLES: rd_value = num_samples_sat;
            REG_NUM_UNITS:   rd_value = 16'(num_units);
            REG_CONFIG:      rd_value = {15'd0, change_only};
            REG_OVERFLOW:    rd_value = overflow;
            REG_DEBUG:       rd_value = 16'hBAAB;
            default:         rd_value = '0;
        endcase
    end

    // FIFO storage (no reset needed; occupancy is tracked by count)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    // Control and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_active_q <= 1'b0;
            wr_active_q <= 1'b0;
            settle_cnt  <= '0;
            stop_q      <= 1'b0;
            change_only <= 1'b0;
            cap_reg     <= '0;
            idx         <= '0;
            num_units   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= '0;
            for (int i = 0; i < int'(MAX_UNITS); i++) begin
                unit_table[i] <= 8'hFF;
                last_val[i]   <= '0;
            end
        end else begin
            rd_active_q <= rd_active;
            wr_active_q <= wr_active;
            settle_cnt  <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
            if (cfg_write) change_only <= ebi_data_in[0];
            if (state == S_CAPTURE) cap_reg <= sample_data[SAMPLE_W-1:0];
            idx       <= idx_next;
            num_units <= num_units_next;
            count     <= count_next;

            if (cmd_reset) begin
                stop_q   <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= '0;
                for (int i = 0; i < int'(MAX_UNITS); i++) begin
                    unit_table[i] <= 8'hFF;
                    last_val[i]   <= '0;
                end
            end else begin
                // Stop is only meaningful while polling; consumed at COMMIT
                if (state == S_COMMIT)                   stop_q <= 1'b0;
                else if (cmd_stop && state != S_IDLE)    stop_q <= 1'b1;
                if (unit_add) unit_table[num_units[IDX_W-1:0]] <= ebi_data_in[7:0];
                if (push) begin
                    wr_ptr        <= wr_ptr + AW'(1);
                    last_val[idx] <= cap_reg;
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                if (want_push && !push && overflow != 16'hFFFF) overflow <= overflow + 16'd1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ebi_data_out   <= '0;
            output_sample  <= 1'b0;
            channel_select <= 8'hFF;
            sampling       <= 1'b0;
            data_avail     <= 1'b0;
        end else begin
            if (rd_stb)          ebi_data_out <= rd_value;
            else if (!rd_active) ebi_data_out <= '0;
            output_sample  <= (state_next == S_FETCH) || (state_next == S_SETTLE);
            sampling       <= (state_next != S_IDLE);
            data_avail     <= (count_next != '0);
            channel_select <= (num_units_next == '0) ? 8'hFF : sel_entry;
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: a default instance (depth 1024) and a
// small-FIFO instance (depth 4) at a neighbouring block position.
module tb_sample_sequencer;

    localparam logic [7:0] POS_M = 8'd242;
    localparam logic [7:0] POS_S = 8'd243;
    localparam logic [7:0] R_NEXT = 8'h01, R_NUMS = 8'h02, R_UNIT = 8'h04, R_CMD = 8'h05;
    localparam logic [7:0] R_NUMU = 8'h06, R_CFG = 8'h07, R_OVF = 8'h08, R_DBG = 8'h0A;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, ebi_data_in;
    logic        cs, re, wr;
    logic [31:0] sample_data;
    logic [15:0] dout_m, dout_s;
    logic        os_m, os_s, samp_m, samp_s, avail_m, avail_s;
    logic [7:0]  chan_m, chan_s;

    int          checks = 0;
    int          failures = 0;
    int          seq [16];
    logic        os_log [64];
    logic        samp_log [64];
    logic [7:0]  chan_log [64];
    logic [15:0] rd;
    logic [31:0] pat;
    int          bad;

    sample_sequencer u_dut (
        .clk(clk), .rst(rst), .addr(addr), .ebi_data_in(ebi_data_in),
        .ebi_data_out(dout_m), .cs(cs), .re(re), .wr(wr),
        .output_sample(os_m), .channel_select(chan_m), .sample_data(sample_data),
        .sampling(samp_m), .data_avail(avail_m)
    );

    sample_sequencer #(.POSITION(243), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .addr(addr), .ebi_data_in(ebi_data_in),
        .ebi_data_out(dout_s), .cs(cs), .re(re), .wr(wr),
        .output_sample(os_s), .channel_select(chan_s), .sample_data(sample_data),
        .sampling(samp_s), .data_avail(avail_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] pos, input logic [7:0] ra, input logic [15:0] d);
        @(negedge clk);
        addr = {pos, ra}; ebi_data_in = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] pos, input logic [7:0] ra, output logic [15:0] d);
        @(negedge clk);
        addr = {pos, ra}; cs = 1'b1; re = 1'b1;
        @(negedge clk);
        d = (pos == POS_M) ? dout_m : dout_s;
        cs = 1'b0; re = 1'b0;
    endtask

    // One iteration per cycle starting right after a start write; logs main
    // instance outputs, feeds seq[poll] as sample data, optionally issues
    // stop (2) or reset (5) commands at given iterations.
    task automatic run_cycles(input logic [7:0] pos, input int ncyc, input int stop_at, input int rst_at);
        for (int i = 0; i < ncyc; i++) begin
            os_log[i]   = os_m;
            samp_log[i] = samp_m;
            chan_log[i] = chan_m;
            sample_data = 32'hFFFF_E000 | 32'(seq[i/4]);
            if (i == stop_at || i == rst_at) begin
                addr = {pos, R_CMD};
                ebi_data_in = (i == stop_at) ? 16'd2 : 16'd5;
                cs = 1'b1; wr = 1'b1;
            end else begin
                cs = 1'b0; wr = 1'b0;
            end
            @(negedge clk);
        end
        cs = 1'b0; wr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs = 1'b0; re = 1'b0; wr = 1'b0;
        addr = '0; ebi_data_in = '0; sample_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dout", 32'(dout_m), 32'h0);
        check("rst_os", 32'(os_m), 32'h0);
        check("rst_chan", 32'(chan_m), 32'hFF);
        check("rst_sampling", 32'(samp_m), 32'h0);
        check("rst_avail", 32'(avail_m), 32'h0);
        bus_read(POS_M, R_CFG, rd);  check("rst_config", 32'(rd), 32'h0);
        bus_read(POS_M, R_NUMS, rd); check("rst_nums", 32'(rd), 32'h0);

        // Two channels, constant sample, 8 polls
        bus_write(POS_M, R_UNIT, 16'd3);
        bus_write(POS_M, R_UNIT, 16'd7);
        bus_read(POS_M, R_NUMU, rd); check("t1_num_units", 32'(rd), 32'd2);
        check("t1_chan_idle", 32'(chan_m), 32'd3);
        for (int k = 0; k < 16; k++) seq[k] = 32'h123;
        bus_write(POS_M, R_CMD, 16'd1);
        run_cycles(POS_M, 32, 28, -1);
        for (int i = 0; i < 32; i++) pat[i] = os_log[i];
        check("t1_strobe_pattern", pat, 32'h3333_3333);
        for (int i = 0; i < 32; i++) pat[i] = samp_log[i];
        check("t1_sampling_pattern", pat, 32'hFFFF_FFFF);
        check("t1_chan_p0", 32'(chan_log[0]), 32'd3);
        check("t1_chan_p1", 32'(chan_log[4]), 32'd7);
        check("t1_chan_p2", 32'(chan_log[8]), 32'd3);
        check("t1_chan_p7", 32'(chan_log[28]), 32'd7);
        check("t1_idle_after_stop", 32'(samp_m), 32'h0);
        check("t1_avail", 32'(avail_m), 32'h1);
        bus_read(POS_M, R_NUMS, rd); check("t1_nums", 32'(rd), 32'd8);
        for (int k = 0; k < 8; k++) begin
            bus_read(POS_M, R_NEXT, rd);
            check($sformatf("t1_pop%0d", k), 32'(rd), (k % 2 == 1) ? 32'h2123 : 32'h0123);
        end
        @(negedge clk);
        check("t1_avail_drained", 32'(avail_m), 32'h0);

        // Change-only filter on one unit
        bus_write(POS_M, R_CMD, 16'd5);
        bus_write(POS_M, R_CFG, 16'd1);
        bus_write(POS_M, R_UNIT, 16'd4);
        seq[0] = 5; seq[1] = 5; seq[2] = 5; seq[3] = 9; seq[4] = 9; seq[5] = 5;
        bus_write(POS_M, R_CMD, 16'd1);
        run_cycles(POS_M, 24, 20, -1);
        bus_read(POS_M, R_NUMS, rd); check("t2_nums", 32'(rd), 32'd3);
        bus_read(POS_M, R_NEXT, rd); check("t2_pop0", 32'(rd), 32'd5);
        bus_read(POS_M, R_NEXT, rd); check("t2_pop1", 32'(rd), 32'd9);
        bus_read(POS_M, R_NEXT, rd); check("t2_pop2", 32'(rd), 32'd5);
        bus_read(POS_M, R_NEXT, rd); check("t2_pop_empty", 32'(rd), 32'd0);

        // Overflow on the depth-4 instance: 10 polls, no reads
        bus_write(POS_S, R_UNIT, 16'd9);
        for (int k = 0; k < 16; k++) seq[k] = k + 1;
        bus_write(POS_S, R_CMD, 16'd1);
        run_cycles(POS_S, 40, 36, -1);
        check("t3_sampling", 32'(samp_s), 32'h0);
        bus_read(POS_S, R_NUMS, rd); check("t3_nums", 32'(rd), 32'd4);
        bus_read(POS_S, R_OVF, rd);  check("t3_overflow", 32'(rd), 32'd6);
        check("t3_avail", 32'(avail_s), 32'h1);
        for (int k = 0; k < 5; k++) begin
            bus_read(POS_S, R_NEXT, rd);
            check($sformatf("t3_pop%0d", k), 32'(rd), (k < 4) ? 32'(k + 1) : 32'd0);
        end
        @(negedge clk);
        check("t3_avail_drained", 32'(avail_s), 32'h0);

        // Table-full boundary and overflow clear on the small instance
        bus_write(POS_S, R_CMD, 16'd5);
        bus_read(POS_S, R_OVF, rd); check("t3_ovf_cleared", 32'(rd), 32'd0);
        for (int k = 0; k < 9; k++) bus_write(POS_S, R_UNIT, 16'(k + 20));
        bus_read(POS_S, R_NUMU, rd); check("t3_table_full", 32'(rd), 32'd8);

        // Stop during SETTLE of unit 1 of 3 (change_only still 1)
        bus_write(POS_M, R_CMD, 16'd5);
        bus_write(POS_M, R_UNIT, 16'd10);
        bus_write(POS_M, R_UNIT, 16'd11);
        bus_write(POS_M, R_UNIT, 16'd12);
        for (int k = 0; k < 16; k++) seq[k] = 5;
        bus_write(POS_M, R_CMD, 16'd1);
        run_cycles(POS_M, 16, 5, -1);
        check("t4_chan_unit1", 32'(chan_log[4]), 32'd11);
        check("t4_sampling_commit", 32'(samp_log[7]), 32'h1);
        check("t4_sampling_fall", 32'(samp_log[8]), 32'h0);
        pat = '0;
        for (int i = 8; i < 16; i++) pat[i] = os_log[i];
        check("t4_no_more_strobes", pat, 32'h0);
        check("t4_chan_idx2", 32'(chan_m), 32'd12);
        bus_read(POS_M, R_NUMS, rd); check("t4_nums", 32'(rd), 32'd2);

        // Reset command mid-SETTLE with FIFO non-empty
        bus_write(POS_M, R_CMD, 16'd1);
        run_cycles(POS_M, 4, -1, 1);
        check("t5_busy_before", 32'(samp_log[1]), 32'h1);
        check("t5_idle_next", 32'(samp_log[2]), 32'h0);
        check("t5_os_off", 32'(os_log[2]), 32'h0);
        check("t5_chan", 32'(chan_m), 32'hFF);
        check("t5_avail", 32'(avail_m), 32'h0);
        bus_read(POS_M, R_NUMU, rd); check("t5_num_units", 32'(rd), 32'd0);
        bus_read(POS_M, R_NUMS, rd); check("t5_nums", 32'(rd), 32'd0);
        bus_read(POS_M, R_CFG, rd);  check("t5_config_kept", 32'(rd), 32'd1);

        // Start with an empty table is ignored
        bus_write(POS_M, R_CMD, 16'd1);
        @(negedge clk);
        check("t5_empty_start", 32'(samp_m), 32'h0);

        // Held read on NEXT_SAMPLE pops once
        bus_write(POS_M, R_UNIT, 16'd20);
        seq[0] = 32'h11; seq[1] = 32'h22;
        bus_write(POS_M, R_CMD, 16'd1);
        run_cycles(POS_M, 8, 4, -1);
        bus_read(POS_M, R_NUMS, rd); check("t6_nums_before", 32'(rd), 32'd2);
        @(negedge clk);
        addr = {POS_M, R_NEXT}; cs = 1'b1; re = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (dout_m !== 16'h0011) bad++;
        end
        check("t6_held_bad_cycles", 32'(bad), 32'd0);
        check("t6_held_value", 32'(dout_m), 32'h0011);
        cs = 1'b0; re = 1'b0;
        @(negedge clk);
        check("t6_dout_release", 32'(dout_m), 32'h0);
        bus_read(POS_M, R_NUMS, rd); check("t6_nums_after", 32'(rd), 32'd1);
        bus_read(POS_M, R_NEXT, rd); check("t6_pop_second", 32'(rd), 32'h0022);
        bus_read(POS_M, R_DBG, rd);  check("t6_debug", 32'(rd), 32'hBAAB);
        bus_read(POS_M, 8'h03, rd);  check("t6_unmapped", 32'(rd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Parametrised multi-channel sample collector on the EBI register bus. It polls up to MAX_UNITS converter channels round-robin and strobes each converter with output_sample. After a configurable settle time it captures sample_data and pushes tagged words into an internal FIFO, which the microcontroller drains through a pop register. Over its predecessor it adds width/depth/channel parameters, settle time, a selectable change-only filter, an overflow counter and status outputs.

## Interface
- POSITION, 242, block select; decoded when addr[15:8] == POSITION
- MAX_UNITS, 8, channel table entries, power of 2, 2..16; IDX_W = log2(MAX_UNITS)
- SAMPLE_W, 13, captured sample bits; IDX_W + SAMPLE_W <= 16
- FIFO_DEPTH, 1024, FIFO words, power of 2
- SETTLE_CYCLES, 1, extra cycles output_sample is held before capture, 0..255
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  16  EBI address
- ebi_data_in  in  16  EBI write data
- ebi_data_out  out  16  EBI read data, registered
- cs, re, wr  in  1 each  EBI chip select, read strobe, write strobe
- output_sample  out  1  converter strobe for the selected channel
- channel_select  out  8  position of the channel being polled
- sample_data  in  32  converter data; bits [SAMPLE_W-1:0] are used
- sampling  out  1  high while the state machine is not in IDLE
- data_avail  out  1  FIFO not empty

## Operation
- Access strobes: rd_stb / wr_stb fire on the first cycle of (cs & addr[15:8]==POSITION & re / wr). Held strobes act once.
- Register map (addr[7:0]):
  - 0x01 NEXT_SAMPLE R: pop; returns the head word, or 0 when empty (no pop).
  - 0x02 NUM_SAMPLES R: FIFO occupancy, saturating at 0xFFFF.
  - 0x04 NEW_UNIT W: appends ebi_data_in[7:0] to the table. Ignored when the table is full or sampling=1.
  - 0x05 COMMAND W: 1 start, 2 stop, 5 reset; other values ignored.
  - 0x06 NUM_UNITS R.
  - 0x07 CONFIG R/W: bit0 change_only, reset value 0.
  - 0x08 OVERFLOW R: count of dropped samples, 16-bit, saturating.
  - 0x0A DEBUG R: 0xBAAB.
  - Unmapped reads return 0.
- FIFO word: {zero pad, idx[IDX_W-1:0], sample_data[SAMPLE_W-1:0]}.
- State machine:
  - IDLE: go to FETCH on start when num_units > 0; start with an empty table is ignored.
  - FETCH: output_sample=1, 1 cycle.
  - SETTLE: output_sample=1, for SETTLE_CYCLES cycles; skipped when SETTLE_CYCLES=0.
  - CAPTURE: output_sample=0; latch sample_data into cap_reg.
  - COMMIT: push decision, then advance idx (wrap at num_units-1 to 0). Next state is IDLE if stop was seen, else FETCH.
- Push rule in COMMIT: push when change_only=0, or when cap_reg[SAMPLE_W-1:0] != last[idx].
  - FIFO full: no push, OVERFLOW increments.
  - last[idx] updates only on a successful push. Reset value of last[] is 0.
- Stop is latched in any state and acted on at the next COMMIT (the current channel completes). Stop in IDLE is ignored.
- Reset command (any state): next cycle → IDLE. Clears the table (all entries 255), num_units, idx, last[], FIFO, OVERFLOW and the stop latch. CONFIG is kept.
- channel_select = table[idx]; 255 when num_units=0.

## Timing
- Reset values: ebi_data_out=0, output_sample=0, channel_select=255, sampling=0, data_avail=0.
  - Internal after reset: FIFO empty, CONFIG=0, table cleared.
- Read data appears on ebi_data_out one cycle after rd_stb and is held while re & cs stay asserted. It is 0 the cycle after deassertion.
- Pop takes effect on rd_stb. data_avail/NUM_SAMPLES reflect it the next cycle.
- Push and pop in the same cycle: both occur, occupancy unchanged. A pop when full frees a slot that is usable at the same cycle's push.
- Per-channel period: 3 + SETTLE_CYCLES cycles. Start → first output_sample: 1 cycle after the COMMAND write strobe.
- Simultaneous reset command and COMMIT: reset wins, no push.

## Test plan
- Table {3,7}, SETTLE=1, change_only=0, start, sample_data constant 0x0123, 8 polls → channel_select alternates 3,7; output_sample high 2 cycles per 4-cycle period; FIFO holds 0x0123, 0x2123 alternating; NUM_SAMPLES=8.
- change_only=1, one unit, sample sequence 5,5,5,9,9,5 → FIFO contains exactly 5,9,5.
- FIFO_DEPTH=4, no reads, 10 polls with change_only=0 → NUM_SAMPLES=4, OVERFLOW=6, data_avail=1; 5 pops → 4 words then 0, data_avail=0.
- Stop written during SETTLE of unit 1 of 3 → unit 1 committed, sampling falls at the following cycle, idx=2, no further output_sample.
- Reset command mid-SETTLE with FIFO non-empty → next cycle IDLE, NUM_UNITS=0, NUM_SAMPLES=0, channel_select=255, CONFIG unchanged.
- Held re on NEXT_SAMPLE for 5 cycles with 2 words queued → exactly one pop; ebi_data_out stable for the whole strobe; DEBUG read returns 0xBAAB.
